// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and framing constants (used by uart_rx and uart_tx).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous 1-bit input, parameterised reset value.
// Latency: 2 clk cycles; no backpressure (free-running sampler).
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with a one-entry holding register.
// Latency: byte/errors appear on the edge after the stop-sample tick; no backpressure, a full holding register drops new bytes (overrun).
module uart_rx #(
  parameter int OVERSAMPLE = uart_pkg::UART_OVERSAMPLE
) (
  input  logic                               mclk,
  input  logic                               reset_n,
  input  logic                               baud_x16,
  input  logic                               serial,
  output logic [uart_pkg::UART_DATA_BITS-1:0] data,
  output logic                               ready,
  input  logic                               data_strobe,
  output logic                               framing_error,
  output logic                               overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                               parity_error
`endif
);
  import uart_pkg::*;

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] FULL_LIM = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LIM = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(UART_DATA_BITS - 1);

  uart_state_t                state, state_next;
  logic                       rx_s;
  logic [CW-1:0]              cnt;
  logic [IW-1:0]              idx;
  logic [UART_DATA_BITS-1:0]  shift;
  logic                       tick_done;
  logic                       deliver;
  logic                       fe_set;
`ifdef UART_RX_PARITY_EN
  logic                       par_err;
  logic                       pe_set;
`endif

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (mclk),
    .rst_n (reset_n),
    .d     (serial),
    .q     (rx_s)
  );

  // START waits half a bit so every later sample lands mid-bit.
  assign tick_done = baud_x16 && (cnt == ((state == ST_START) ? HALF_LIM : FULL_LIM));

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    deliver    = 1'b0;
    fe_set     = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_set     = 1'b0;
`endif
    case (state)
      ST_IDLE:  if (!rx_s) state_next = ST_START;
      ST_START: if (tick_done) state_next = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (tick_done && idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (tick_done) state_next = ST_STOP;
`endif
      ST_STOP: begin
        if (tick_done) begin
          if (!rx_s) begin
            fe_set     = 1'b1;
            state_next = ST_BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_err) begin
            pe_set     = 1'b1;
            state_next = ST_IDLE;
`endif
          end else begin
            deliver    = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_BREAK: if (rx_s) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
`ifdef UART_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      if (state == ST_IDLE || state == ST_BREAK || state != state_next || tick_done)
        cnt <= '0;
      else if (baud_x16)
        cnt <= cnt + 1'b1;

      if (state == ST_START && tick_done)
        idx <= '0;
      if (state == ST_DATA && tick_done) begin
        shift[idx] <= rx_s;
        idx        <= idx + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      // Even parity: data bits plus parity bit must XOR to zero.
      if (state == ST_PARITY && tick_done)
        par_err <= (^shift) ^ rx_s;
`endif
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      data          <= '0;
      ready         <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
    end else begin
      framing_error <= fe_set;
      overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= pe_set;
`endif
      // A same-cycle acknowledge frees the register for the incoming byte.
      if (deliver) begin
        if (!ready || data_strobe) begin
          data  <= shift;
          ready <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_strobe) begin
        ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level stimulus against a holding-register reference model.
module tb_uart_rx;

  localparam int OS  = 16;
  localparam int TPB = 4;

  logic       mclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_x16;
  logic       serial = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       data_strobe = 1'b0;
  logic       framing_error;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  logic [1:0] div = 2'd0;

  int n_vec = 0;
  int n_err = 0;

  logic       m_ready = 1'b0;
  logic [7:0] m_data  = 8'h00;
  int         m_ovr = 0, m_fe = 0, m_pe = 0;
  int         ovr_cnt = 0, fe_cnt = 0, pe_cnt = 0;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .mclk          (mclk),
    .reset_n       (reset_n),
    .baud_x16      (baud_x16),
    .serial        (serial),
    .data          (data),
    .ready         (ready),
    .data_strobe   (data_strobe),
    .framing_error (framing_error),
    .overrun       (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error  (parity_error)
`endif
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) div <= div + 2'd1;
  assign baud_x16 = (div == 2'd3);

  always @(negedge mclk) begin
    if (framing_error === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_error === 1'b1) pe_cnt++;
`endif
  end

  task automatic drive_bit(input logic b, input int ticks);
    serial = b;
    repeat (ticks * TPB) @(negedge mclk);
  endtask

  task automatic send_raw(input logic [7:0] b, input logic stop_bit, input int stop_ticks);
    drive_bit(1'b0, OS);
    for (int i = 0; i < 8; i++) drive_bit(b[i], OS);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b, OS);
`endif
    drive_bit(stop_bit, stop_ticks);
    serial = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_raw(b, 1'b1, OS);
  endtask

  // Reference behaviour of the holding register on a good frame.
  task automatic model_deliver(input logic [7:0] b);
    if (!m_ready) begin
      m_ready = 1'b1;
      m_data  = b;
    end else begin
      m_ovr++;
    end
  endtask

  task automatic do_ack();
    data_strobe = 1'b1;
    @(negedge mclk);
    data_strobe = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge mclk);
    n_vec++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ready); end
    n_vec++;
    if (data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", data); end
    n_vec++;
    if (framing_error !== 1'b0 || overrun !== 1'b0) begin
      n_err++; $display("FAIL reset_pulses got fe=%b ovr=%b exp=0/0", framing_error, overrun);
    end
    reset_n = 1'b1;
    drive_bit(1'b1, 2 * OS);
  endtask

  task automatic test_single();
    send_frame(8'h55);
    model_deliver(8'h55);
    n_vec++;
    if (ready !== m_ready || data !== m_data) begin
      n_err++; $display("FAIL single_rx got rdy=%b dat=%h exp rdy=%b dat=%h", ready, data, m_ready, m_data);
    end
    do_ack();
    n_vec++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL single_ack got=%b exp=0", ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [2];
    seq[0] = 8'hA3;
    seq[1] = 8'h0F;
    for (int i = 0; i < 2; i++) begin
      send_frame(seq[i]);
      model_deliver(seq[i]);
      n_vec++;
      if (ready !== m_ready || data !== m_data) begin
        n_err++; $display("FAIL b2b_rx%0d got rdy=%b dat=%h exp rdy=%b dat=%h", i, ready, data, m_ready, m_data);
      end
      do_ack();
    end
    send_frame(8'h11);
    model_deliver(8'h11);
    send_frame(8'h22);
    model_deliver(8'h22);
    n_vec++;
    if (ready !== m_ready || data !== m_data) begin
      n_err++; $display("FAIL overrun_keep got rdy=%b dat=%h exp rdy=%b dat=%h", ready, data, m_ready, m_data);
    end
    n_vec++;
    if (ovr_cnt !== m_ovr) begin n_err++; $display("FAIL overrun_pulse got=%0d exp=%0d", ovr_cnt, m_ovr); end
    do_ack();
    n_vec++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL overrun_ack got=%b exp=0", ready); end
  endtask

  task automatic test_false_start();
    drive_bit(1'b1, 4);
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 2 * OS);
    n_vec++;
    if (ready !== 1'b0 || fe_cnt !== m_fe || ovr_cnt !== m_ovr) begin
      n_err++; $display("FAIL false_start got rdy=%b fe=%0d ovr=%0d exp rdy=0 fe=%0d ovr=%0d", ready, fe_cnt, ovr_cnt, m_fe, m_ovr);
    end
    send_frame(8'h7E);
    model_deliver(8'h7E);
    n_vec++;
    if (ready !== m_ready || data !== m_data) begin
      n_err++; $display("FAIL after_glitch got rdy=%b dat=%h exp rdy=%b dat=%h", ready, data, m_ready, m_data);
    end
    do_ack();
  endtask

  task automatic test_framing();
    send_raw(8'hE7, 1'b0, 30);
    m_fe++;
    drive_bit(1'b1, 2 * OS);
    n_vec++;
    if (fe_cnt !== m_fe) begin n_err++; $display("FAIL framing_pulse got=%0d exp=%0d", fe_cnt, m_fe); end
    n_vec++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL framing_ready got=%b exp=0", ready); end
    send_frame(8'hC4);
    model_deliver(8'hC4);
    n_vec++;
    if (ready !== m_ready || data !== m_data) begin
      n_err++; $display("FAIL after_break got rdy=%b dat=%h exp rdy=%b dat=%h", ready, data, m_ready, m_data);
    end
    do_ack();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h5A;
    send_frame(8'h3C);
    model_deliver(8'h3C);
    drive_bit(1'b0, OS);
    for (int i = 0; i < 3; i++) drive_bit(b[i], OS);
    drive_bit(b[3], OS / 2);
    reset_n = 1'b0;
    serial  = 1'b1;
    m_ready = 1'b0;
    m_data  = 8'h00;
    #1;
    n_vec++;
    if (ready !== m_ready || data !== m_data) begin
      n_err++; $display("FAIL midframe_reset got rdy=%b dat=%h exp rdy=%b dat=%h", ready, data, m_ready, m_data);
    end
    repeat (4) @(negedge mclk);
    reset_n = 1'b1;
    drive_bit(1'b1, 2 * OS);
    send_frame(8'h96);
    model_deliver(8'h96);
    n_vec++;
    if (ready !== m_ready || data !== m_data) begin
      n_err++; $display("FAIL after_reset got rdy=%b dat=%h exp rdy=%b dat=%h", ready, data, m_ready, m_data);
    end
    do_ack();
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 40)) @(negedge mclk);
      send_frame(b);
      model_deliver(b);
      n_vec++;
      if (ready !== m_ready || data !== m_data || ovr_cnt !== m_ovr) begin
        n_err++; $display("FAIL rand%0d got rdy=%b dat=%h ovr=%0d exp rdy=%b dat=%h ovr=%0d",
                          i, ready, data, ovr_cnt, m_ready, m_data, m_ovr);
      end
      if ($urandom_range(0, 2) != 0) do_ack();
    end
    do_ack();
    n_vec++;
    if (fe_cnt !== m_fe || pe_cnt !== m_pe) begin
      n_err++; $display("FAIL rand_errors got fe=%0d pe=%0d exp fe=%0d pe=%0d", fe_cnt, pe_cnt, m_fe, m_pe);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] b;
    b = 8'h01;
    for (int k = 0; k < 2; k++) begin
      drive_bit(1'b0, OS);
      for (int i = 0; i < 8; i++) drive_bit(b[i], OS);
      drive_bit((k == 0) ? 1'b1 : 1'b0, OS);
      drive_bit(1'b1, 2 * OS);
      if (k == 0) model_deliver(b);
      else m_pe++;
      n_vec++;
      if (ready !== m_ready || data !== m_data || pe_cnt !== m_pe) begin
        n_err++; $display("FAIL parity%0d got rdy=%b dat=%h pe=%0d exp rdy=%b dat=%h pe=%0d",
                          k, ready, data, pe_cnt, m_ready, m_data, m_pe);
      end
      do_ack();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_framing();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-wide asynchronous serial receiver; the receive-side counterpart of `uart_tx`. Samples the incoming serial line using a 16× baud enable strobe, deframes 8N1 characters (optionally 8E1), and presents each byte through a one-entry holding register with a ready/strobe handshake. This matches the `uart_rx_ready`/`uart_rx_strobe`/`uart_rx_data` style used by the USB serial path, so a bridge can feed received bytes straight into `usb_serial`.

## Interface
- `OVERSAMPLE`, default 16: enable ticks per bit. Must be even and ≥ 8.
- `mclk` input, 1 bit: system clock. All logic is on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `baud_x16` input, 1 bit: enable strobe in the `mclk` domain, one cycle high per oversample tick.
- `serial` input, 1 bit: asynchronous RX line. Idles high.
- `data` output, 8 bits: received byte. Valid while `ready` is high.
- `ready` output, 1 bit: holding register is full.
- `data_strobe` input, 1 bit: consumer acknowledge. Single-cycle pulse that empties the holding register.
- `framing_error` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `overrun` output, 1 bit: one-cycle pulse when a byte is dropped because the holding register is full.
- `parity_error` output, 1 bit: one-cycle pulse on parity mismatch. Present only with `UART_RX_PARITY_EN`.

## Operation
- **Input synchronizer:** `serial` passes through a 2-flop synchronizer. Both flops reset to 1.
- **Tick counter:** counts `baud_x16` ticks; no other logic advances on ticks.
- **State machine:**
  - IDLE: when the synced line is 0 → START, tick counter cleared.
  - START: after OVERSAMPLE/2 ticks, sample the line. If 0 → DATA with bit index 0. If 1 → IDLE (false start, no error flagged).
  - DATA: every OVERSAMPLE ticks, sample the line into `shift[idx]`, LSB first. After bit 7 → PARITY if enabled, otherwise → STOP.
  - PARITY: after OVERSAMPLE ticks, sample the parity bit. Even parity: XOR of the 8 data bits and the parity bit must be 0.
  - STOP: after OVERSAMPLE ticks, sample the line.
    - If 1 and no parity error: deliver the byte, then → IDLE.
    - If 0: pulse `framing_error`, discard the byte, → BREAK.
    - On parity error: pulse `parity_error`, discard the byte, → IDLE.
  - BREAK: wait for the synced line to be 1, then → IDLE.
- **Delivery:**
  - If `ready`=0: load `data` and set `ready`.
  - If `ready`=1 with no `data_strobe` in the same cycle: pulse `overrun`; the old byte is kept and the new byte is dropped.
- **Handshake:**
  - `data_strobe` while `ready`=1 clears `ready` on the next edge.
  - `data_strobe` while `ready`=0 is ignored.
  - If `data_strobe` and delivery happen in the same cycle: the new byte loads, `ready` stays 1, and `overrun` does not pulse.
- **Reset values:** `data`=0x00, `ready`=0, all error pulses 0, state IDLE, shift register 0.
- **Reset mid-frame:** the frame is abandoned. After release, the receiver resynchronises on the next falling edge seen from IDLE.

## Timing
- **Start detection:** the falling edge reaches the FSM 2 `mclk` cycles after it appears on `serial` (synchronizer latency).
- **Stop sample point (8N1):** OVERSAMPLE/2 + 9·OVERSAMPLE ticks after start detection, i.e. 152 ticks at the default.
- **Parity frames (8E1):** add OVERSAMPLE ticks, i.e. 168 ticks.
- **Delivery:** `ready` rises, `data` updates and error pulses fire on the `mclk` edge after the stop-sample tick.
- **Back-to-back frames:** a new start bit is accepted as early as the tick after returning to IDLE. Stop bits are sampled mid-bit, so the receiver tolerates roughly ±3% baud mismatch.
- **Tick rate:** `baud_x16` held high continuously counts one tick per `mclk` cycle, which is legal for simulation.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - PARITY state is compiled in and the `parity_error` port exists.
  - Frames are 8E1.
- **`UART_RX_PARITY_EN` undefined:**
  - No PARITY state and no `parity_error` port.
  - Frames are 8N1.

## Structure
- **Shared package `uart_pkg`:**
  - State encodings: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Default oversample constant: 16.
  - Bit-count constant: 8.
  - `uart_tx` also uses this package.
- **Sub-module `sync2`:** the 2-flop synchronizer, with a parameterised reset value (1 here). It is reusable for other asynchronous inputs.

## Test plan
- **Single byte:** send 0x55 8N1, `baud_x16` every 4 `mclk` cycles → `ready` rises with `data`=0x55; `data_strobe` → `ready`=0 next cycle.
- **Back-to-back, then overrun:** send 0xA3 then 0x0F back-to-back, acking after each → both bytes delivered in order. Then send 0x11 and 0x22 without acking → `data`=0x11 stays, with one `overrun` pulse.
- **False start:** drive a low glitch for 4 ticks on idle `serial` → no `ready` and no error pulse; the next valid 0x7E is received correctly.
- **Framing error:** send a frame with stop bit=0 and hold the line low for 30 ticks → one `framing_error` pulse and no `ready`. After the line goes high, 0xC4 is received correctly.
- **Reset mid-frame:** assert `reset_n`=0 during data bit 3 → all outputs take reset values immediately. The next full frame, 0x96, is received correctly.
- **Parity (with `UART_RX_PARITY_EN`):** 0x01 with parity bit 1 → delivered. 0x01 with parity bit 0 → `parity_error` pulse and no `ready`.
